bcd_conv_arbiter: RTL and testbench
===================================

// Module: bcd_conv_arbiter
// PURPOSE
//  Round-robin scheduler sharing one val_bcd binary-to-BCD converter among N_REQ requesters
//  (result path, operand preview, op menu, history). Sequences the converter's level-enable/rdy
//  protocol, returns the 16-bit BCD word to the granted requester with a one-cycle done pulse.
//  Sits between the control FSMs and the single val_bcd instance feeding the bcd_seg/Multi_Driver path.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  DATA_W   12    binary value width (matches val_bcd count)
//  BCD_W    16    BCD result width (4 digits)
//  TIMEOUT  4095  converter watchdog limit in cycles (used only with BCD_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1               system clock, all logic on posedge
//  rst       in   1               asynchronous, active-high reset
//  req       in   N_REQ           per-requester request level; held until own done
//  req_data  in   N_REQ*DATA_W    value of requester i at [i*DATA_W +: DATA_W]
//  gnt       out  N_REQ           one-hot grant, high from GRANT through DONE
//  done      out  N_REQ           one-cycle pulse to granted requester when bcd_out valid
//  bcd_out   out  BCD_W           last result, held until next done
//  busy      out  1               high in any state except IDLE
//  err       out  1               sticky watchdog error (tied 0 without BCD_ARB_TIMEOUT_EN)
//  conv_en   out  1               level enable to val_bcd
//  conv_cnt  out  DATA_W          value presented to val_bcd, stable while conv_en high
//  conv_rdy  in   1               val_bcd conversion complete
//  conv_bcd  in   BCD_W           val_bcd result, sampled on conv_rdy
// BEHAVIOUR
//  Reset (async): state IDLE, gnt=0, done=0, bcd_out=0, busy=0, err=0, conv_en=0, conv_cnt=0, ptr=0.
//  States: IDLE -> GRANT -> CONV -> DONE -> GAP -> IDLE.
//   IDLE : if |req, pick winner = first asserted index at or after ptr (wrap mod N_REQ); go GRANT.
//   GRANT: gnt[w]=1, latch conv_cnt <= req_data[w]; go CONV.
//   CONV : conv_en=1; on conv_rdy latch bcd_out <= conv_bcd, conv_en<=0, go DONE.
//   DONE : done[w] pulses 1 cycle; ptr <= (w+1) mod N_REQ; gnt cleared on exit.
//   GAP  : conv_en held 0 one cycle so val_bcd re-arms; go IDLE.
//  Latency: req seen at edge t -> gnt at t+1, conv_en at t+2, conv_rdy at t+2+k -> done at t+3+k.
//  Requester data sampled once in GRANT; later changes to req_data ignored until next grant.
//  req dropped mid-conversion: conversion completes, done still pulses, bcd_out updated.
//  conv_rdy outside CONV is ignored. Non-winning requests stay pending, no starvation: max wait
//  (N_REQ-1) full services. Single requester re-requesting is serviced back-to-back (GAP only).
//  ptr advances only after a completed service; reset mid-operation aborts immediately, conv_en=0.
// CONFIGURATION
//  BCD_ARB_TIMEOUT_EN defined: cycle counter in CONV; reaching TIMEOUT without conv_rdy sets err
//   (sticky until rst), forces conv_en=0, delivers done with bcd_out=16'hFFFF, ptr advances, GAP.
//  Undefined: no counter, CONV waits on conv_rdy indefinitely, err tied 0.
// STRUCTURE
//  Package bcd_arb_pkg: state encoding localparams (IDLE..GAP, 3 bits), BCD_ERR_WORD=16'hFFFF.
//  Sub-module rr_pick: combinational round-robin selector (req, ptr -> one-hot winner, valid).
//  Top holds FSM, ptr, data mux, output registers, optional watchdog.
// TESTING
//  1 req=0001, data0=12'd237, model rdy after 5 cyc -> done=0001 once, bcd_out=16'h0237.
//  2 req=1111 held, each data=i*100 -> grants 0,1,2,3,0 in order; bcd_out 0000,0100,0200,0300.
//  3 req=0100 then req0 set during CONV -> req2 completes first, then gnt=0001; ptr=3 after req2.
//  4 data0=12'd4095 -> bcd_out=16'h4095; data changed during CONV -> result still 4095.
//  5 rst asserted mid-CONV -> same cycle conv_en=0, gnt=0, busy=0; ptr=0 afterwards.
//  6 TIMEOUT=20, rdy never -> (EN) err=1, done pulse, bcd_out=FFFF at 20 cyc; (no EN) busy stays 1.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared encodings and helpers for the bcd_conv_arbiter slice.
// The optional converter watchdog is enabled by defining BCD_ARB_TIMEOUT_EN.
package bcd_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GRANT = 3'd1;
    localparam state_t ST_CONV  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Result word delivered when the watchdog abandons a conversion.
    localparam logic [15:0] BCD_ERR_WORD = 16'hFFFF;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr_i,
// wrapping modulo N_REQ, returned both as an index and as a one-hot vector.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    always_comb begin
        int          cand;
        logic [PW-1:0] cand_idx;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[PW-1:0];
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin scheduler sharing one val_bcd converter among N_REQ requesters.
// Define BCD_ARB_TIMEOUT_EN to add the CONV-state watchdog and sticky err flag.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 12,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [BCD_W-1:0]        bcd_out,
    output logic                    busy,
    output logic                    err,
    output logic                    conv_en,
    output logic [DATA_W-1:0]       conv_cnt,
    input  logic                    conv_rdy,
    input  logic [BCD_W-1:0]        conv_bcd
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              state_q, state_d;
    logic [PW-1:0]       win_q, win_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                conv_en_q, conv_en_d;
    logic [DATA_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic                timeout_hit;

    logic [N_REQ-1:0]    pick_onehot;
    logic [PW-1:0]       pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            bcd_q      <= '0;
            conv_en_q  <= 1'b0;
            conv_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            conv_en_q  <= conv_en_d;
            conv_cnt_q <= conv_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_CONV;
            ST_CONV:  if (conv_rdy || timeout_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_d      = win_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        bcd_d      = bcd_q;
        conv_en_d  = conv_en_q;
        conv_cnt_d = conv_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d = pick_idx;
                    gnt_d = pick_onehot;
                end
            end
            ST_GRANT: begin
                // Operand is captured exactly once; later req_data edits are ignored.
                conv_cnt_d = data_arr[win_q];
                conv_en_d  = 1'b1;
            end
            ST_CONV: begin
                if (conv_rdy) begin
                    bcd_d     = conv_bcd;
                    conv_en_d = 1'b0;
                    done_d    = gnt_q;
                end else if (timeout_hit) begin
                    bcd_d     = BCD_W'(BCD_ERR_WORD);
                    conv_en_d = 1'b0;
                    done_d    = gnt_q;
                end
            end
            ST_DONE: begin
                gnt_d = '0;
                ptr_d = PW'(wrap_inc(int'(win_q), N_REQ));
            end
            default: begin
                conv_en_d = 1'b0;
            end
        endcase
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    always_comb begin
        tmo_d       = (state_q == ST_CONV) ? tmo_q + 1'b1 : '0;
        timeout_hit = (state_q == ST_CONV) && (tmo_q == TW'(TIMEOUT - 1)) && !conv_rdy;
        err_d       = err_q | timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign busy     = (state_q != ST_IDLE);
    assign conv_en  = conv_en_q;
    assign conv_cnt = conv_cnt_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed table, corner sequences,
// and a randomized phase against a service-level round-robin model.
module tb_bcd_conv_arbiter;

    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int BW  = 16;
    localparam int TMO = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, done;
    logic [BW-1:0]   bcd_out;
    logic            busy, err, conv_en;
    logic [DW-1:0]   conv_cnt;
    logic            conv_rdy;
    logic [BW-1:0]   conv_bcd;

    logic            cv_rdy;
    logic [BW-1:0]   cv_bcd;
    logic            force_rdy;
    logic [BW-1:0]   force_bcd;
    int              cv_lat;
    bit              cv_block;
    int              cv_cnt;

    int checks = 0;
    int errors = 0;

    assign conv_rdy = cv_rdy | force_rdy;
    assign conv_bcd = force_rdy ? force_bcd : cv_bcd;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(
        .N_REQ(N), .DATA_W(DW), .BCD_W(BW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .bcd_out(bcd_out), .busy(busy), .err(err),
        .conv_en(conv_en), .conv_cnt(conv_cnt), .conv_rdy(conv_rdy), .conv_bcd(conv_bcd)
    );

    function automatic logic [15:0] bin2bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural val_bcd: rdy after cv_lat cycles of enable, one-cycle pulse.
    always @(negedge clk) begin
        if (rst || !conv_en) begin
            cv_cnt = 0;
            cv_rdy = 1'b0;
        end else if (cv_rdy) begin
            cv_rdy = 1'b0;
        end else begin
            cv_cnt++;
            if (!cv_block && cv_cnt >= cv_lat) begin
                cv_rdy = 1'b1;
                cv_bcd = bin2bcd(int'(conv_cnt));
            end
        end
    end

    // Service-level model: decision edge, round-robin winner, done edge, result.
    int         cyc = 0;
    bit         mdl_on = 1'b0;
    int         free_edge, m_ptr, m_w, m_from, m_done, m_c;
    bit         m_active;
    logic [15:0] m_bcd;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ptr     = 0;
            free_edge = 0;
            m_active  = 1'b0;
        end else if (mdl_on && cyc >= free_edge && req != '0) begin
            m_w = -1;
            for (int off = 0; off < N; off++) begin
                m_c = (m_ptr + off) % N;
                if (m_w < 0 && req[m_c]) m_w = m_c;
            end
            cv_lat    = int'($urandom_range(1, 8));
            m_from    = cyc;
            m_done    = cyc + cv_lat + 1;
            free_edge = cyc + cv_lat + 4;
            m_bcd     = bin2bcd(int'(req_data[m_w*DW +: DW]));
            m_ptr     = (m_w + 1) % N;
            m_active  = 1'b1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_conv_en(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (conv_en) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: conv_en never rose within 50 cycles", tag);
        end
    endtask

    task automatic wait_done(input string tag, output logic [3:0] d, output logic [3:0] g,
                             output logic [15:0] b);
        bit seen = 1'b0;
        d = '0; g = '0; b = '0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) begin
                d = done; g = gnt; b = bcd_out; seen = 1'b1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within 200 cycles", tag);
        end
        $display("txn %s: done=%b gnt=%b bcd_out=%h", tag, d, g, b);
    endtask

    task automatic service(input int idx, input logic [11:0] data, input int lat,
                           output logic [3:0] d, output logic [15:0] b,
                           output int edges, output int ndone);
        req_data[idx*DW +: DW] = data;
        cv_lat   = lat;
        req[idx] = 1'b1;
        edges = 0; ndone = 0; d = '0; b = '0;
        for (int c = 0; c < 200 && ndone == 0; c++) begin
            @(negedge clk);
            edges++;
            if (done != '0) begin
                ndone = 1; d = done; b = bcd_out;
            end
        end
        if (ndone == 0) begin
            checks++;
            errors++;
            $display("FAIL svc_timeout: req%0d got no done within 200 cycles", idx);
        end
        req[idx] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done != '0) ndone++;
        end
        $display("txn svc req%0d data=%0d lat=%0d: done=%b bcd_out=%h edges=%0d pulses=%0d",
                 idx, data, lat, d, b, edges, ndone);
    endtask

    typedef struct {
        int          idx;
        logic [11:0] data;
        int          lat;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [3:0]  d, g, oh;
    logic [15:0] b;
    int          edges, ndone, m_count;
    int          idle_cnt [N];
    logic [3:0]  exp_order [5];
    logic [15:0] exp_bcd2  [5];

    initial begin
        vecs[0] = '{0, 12'd237,  5, 16'h0237};
        vecs[1] = '{1, 12'd4095, 3, 16'h4095};
        vecs[2] = '{2, 12'd0,    1, 16'h0000};
        vecs[3] = '{3, 12'd9,    2, 16'h0009};
        vecs[4] = '{0, 12'd100,  7, 16'h0100};
        vecs[5] = '{1, 12'd999,  4, 16'h0999};
        vecs[6] = '{2, 12'd1000, 1, 16'h1000};
        vecs[7] = '{3, 12'd2048, 6, 16'h2048};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bcd2  = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0000};

        rst = 1'b1; req = '0; req_data = '0; force_rdy = 1'b0; force_bcd = '0;
        cv_block = 1'b0; cv_lat = 1; cv_rdy = 1'b0; cv_bcd = '0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_conv_en", 32'(conv_en), 0);
        chk("rst_conv_cnt", 32'(conv_cnt), 0);
        @(negedge clk);
        do_reset();

        // Table-driven single-requester conversions
        for (int i = 0; i < 8; i++) begin
            service(vecs[i].idx, vecs[i].data, vecs[i].lat, d, b, edges, ndone);
            oh = '0;
            oh[vecs[i].idx] = 1'b1;
            chk("tbl_pulses", 32'(ndone), 1);
            chk("tbl_done", 32'(d), 32'(oh));
            chk("tbl_bcd", 32'(b), 32'(vecs[i].exp));
            chk("tbl_latency", 32'(edges), 32'(vecs[i].lat + 2));
        end

        // All four held: strict rotation 0,1,2,3,0
        do_reset();
        cv_lat = 3;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 12'(i * 100);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done("rotate", d, g, b);
            chk("rot_done", 32'(d), 32'(exp_order[i]));
            chk("rot_gnt", 32'(g), 32'(exp_order[i]));
            chk("rot_bcd", 32'(b), 32'(exp_bcd2[i]));
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Late request during CONV waits for current service
        do_reset();
        cv_lat = 4;
        req_data[2*DW +: DW] = 12'd42;
        req[2] = 1'b1;
        wait_conv_en("late_req");
        req_data[0 +: DW] = 12'd7;
        req[0] = 1'b1;
        wait_done("late_first", d, g, b);
        chk("late_first_done", 32'(d), 32'b0100);
        chk("late_first_bcd", 32'(b), 32'h0042);
        req[2] = 1'b0;
        wait_done("late_second", d, g, b);
        chk("late_second_done", 32'(d), 32'b0001);
        chk("late_second_gnt", 32'(g), 32'b0001);
        chk("late_second_bcd", 32'(b), 32'h0007);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);

        // ptr lands on 3 after serving requester 2
        do_reset();
        service(2, 12'd11, 2, d, b, edges, ndone);
        req_data[1*DW +: DW] = 12'd21;
        req_data[3*DW +: DW] = 12'd33;
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_done("ptr_a", d, g, b);
        chk("ptr_a_done", 32'(d), 32'b1000);
        chk("ptr_a_bcd", 32'(b), 32'h0033);
        req[3] = 1'b0;
        wait_done("ptr_b", d, g, b);
        chk("ptr_b_done", 32'(d), 32'b0010);
        chk("ptr_b_bcd", 32'(b), 32'h0021);
        req[1] = 1'b0;
        repeat (4) @(negedge clk);

        // conv_rdy while IDLE is ignored
        force_bcd = 16'h1234;
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        @(negedge clk);
        chk("stray_rdy_bcd", 32'(bcd_out), 32'h0021);
        chk("stray_rdy_done", 32'(done), 0);
        chk("stray_rdy_busy", 32'(busy), 0);

        // Operand frozen at grant; req dropped mid-conversion still completes
        cv_lat = 8;
        req_data[0 +: DW] = 12'd4095;
        req[0] = 1'b1;
        wait_conv_en("freeze");
        req_data[0 +: DW] = 12'd123;
        req[0] = 1'b0;
        @(negedge clk);
        chk("freeze_conv_cnt", 32'(conv_cnt), 32'd4095);
        wait_done("freeze", d, g, b);
        chk("freeze_done", 32'(d), 32'b0001);
        chk("freeze_bcd", 32'(b), 32'h4095);
        repeat (4) @(negedge clk);

        // Reset mid-CONV aborts immediately and returns ptr to 0
        do_reset();
        service(2, 12'd50, 2, d, b, edges, ndone);
        cv_lat = 50;
        req_data[3*DW +: DW] = 12'd77;
        req[3] = 1'b1;
        wait_conv_en("abort");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_conv_en", 32'(conv_en), 0);
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bcd", 32'(bcd_out), 0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        cv_lat = 3;
        @(negedge clk);
        req_data[1*DW +: DW] = 12'd5;
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_done("abort_after_a", d, g, b);
        chk("abort_after_a_done", 32'(d), 32'b0010);
        chk("abort_after_a_bcd", 32'(b), 32'h0005);
        req[1] = 1'b0;
        wait_done("abort_after_b", d, g, b);
        chk("abort_after_b_done", 32'(d), 32'b1000);
        chk("abort_after_b_bcd", 32'(b), 32'h0077);
        req[3] = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic against the service-level model
        do_reset();
        mdl_on = 1'b1;
        m_count = 0;
        for (int i = 0; i < N; i++) idle_cnt[i] = int'($urandom_range(0, 3));
        for (int c = 0; c < 3000 && m_count < 40; c++) begin
            logic [3:0] e_oh;
            @(negedge clk);
            e_oh = '0;
            if (m_active) e_oh[m_w] = 1'b1;
            chk("rnd_gnt", 32'(gnt), (m_active && cyc >= m_from && cyc <= m_done) ? 32'(e_oh) : 0);
            chk("rnd_done", 32'(done), (m_active && cyc == m_done) ? 32'(e_oh) : 0);
            chk("rnd_busy", 32'(busy), (m_active && cyc >= m_from && cyc <= m_done + 1) ? 1 : 0);
            if (m_active && cyc == m_done) begin
                chk("rnd_bcd", 32'(bcd_out), 32'(m_bcd));
                $display("txn rnd #%0d: req%0d bcd_out=%h expected=%h", m_count, m_w, bcd_out, m_bcd);
                req[m_w] = 1'b0;
                idle_cnt[m_w] = int'($urandom_range(0, 4));
                m_count++;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if (idle_cnt[i] == 0) begin
                        req_data[i*DW +: DW] = 12'($urandom_range(0, 4095));
                        req[i] = 1'b1;
                    end else begin
                        idle_cnt[i]--;
                    end
                end
            end
        end
        chk("rnd_progress", 32'(m_count), 40);
        mdl_on = 1'b0;
        req = '0;
        repeat (15) @(negedge clk);

        // Converter never answers
        do_reset();
        cv_block = 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
        service(0, 12'd555, 5, d, b, edges, ndone);
        chk("tmo_done", 32'(d), 32'b0001);
        chk("tmo_pulses", 32'(ndone), 1);
        chk("tmo_bcd", 32'(b), 32'hFFFF);
        chk("tmo_latency", 32'(edges), 32'(TMO + 2));
        chk("tmo_err", 32'(err), 1);
        cv_block = 1'b0;
        service(1, 12'd321, 2, d, b, edges, ndone);
        chk("tmo_next_bcd", 32'(b), 32'h0321);
        chk("tmo_err_sticky", 32'(err), 1);
`else
        cv_lat = 5;
        req_data[0 +: DW] = 12'd555;
        req[0] = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done != '0) ndone++;
        end
        chk("hang_busy", 32'(busy), 1);
        chk("hang_no_done", 32'(ndone), 0);
        chk("hang_conv_en", 32'(conv_en), 1);
        chk("hang_err", 32'(err), 0);
        cv_block = 1'b0;
        wait_done("hang_release", d, g, b);
        chk("hang_release_bcd", 32'(b), 32'h0555);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
`endif
        do_reset();
        chk("final_err_clear", 32'(err), 0);
        chk("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
